// File: rtl/ins_fetcher_if.sv
// Fetch-side bus of the instruction fetcher: decoder handshake, ROB flush and
// memory-controller word reads. master = fetcher, slave = decoder/ROB/MC side.
interface ins_fetcher_if;
   logic        Decoder_ins_ready;
   logic [31:0] Decoder_ins;
   logic [31:0] Decoder_pc;
   logic [31:0] Decoder_predict_nxt_pc;
   logic        Decoder_stall;
   logic        Decoder_clear;
   logic [31:0] Decoder_new_addr;
   logic        ROB_clear;
   logic [31:0] ROB_new_pc;
   logic        MC_req;
   logic [31:0] MC_addr;
   logic        MC_done;
   logic [31:0] MC_data;

   modport master (
      output Decoder_ins_ready, Decoder_ins, Decoder_pc, Decoder_predict_nxt_pc,
      output MC_req, MC_addr,
      input  Decoder_stall, Decoder_clear, Decoder_new_addr,
      input  ROB_clear, ROB_new_pc, MC_done, MC_data
   );

   modport slave (
      input  Decoder_ins_ready, Decoder_ins, Decoder_pc, Decoder_predict_nxt_pc,
      input  MC_req, MC_addr,
      output Decoder_stall, Decoder_clear, Decoder_new_addr,
      output ROB_clear, ROB_new_pc, MC_done, MC_data
   );
endinterface

// File: rtl/ins_fetcher.sv
// Instruction fetch unit: fetch PC, direct-mapped one-word-per-line icache,
// static next-PC prediction and decoder/ROB redirect handling.
module ins_fetcher #(
   parameter logic [31:0] RESET_PC   = 32'h0,
   parameter int          ICACHE_IDX = 4
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          rdy_in,
   ins_fetcher_if.master bus
);
   localparam int         ENTRIES   = 1 << ICACHE_IDX;
   localparam int         TAG_W     = 30 - ICACHE_IDX;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [2:0] {FETCH, MISS, PRESENT, WAIT_JALR, DRAIN} state_t;
   state_t state, next_state;

   logic [31:0]        fetch_pc;
   logic [31:0]        data_mem [ENTRIES];
   logic [TAG_W-1:0]   tag_mem  [ENTRIES];
   logic [ENTRIES-1:0] valid;

   logic        ins_ready;
   logic [31:0] ins_q, pc_q, pred_q;
   logic        mc_req;
   logic [31:0] mc_addr;

   logic [ICACHE_IDX-1:0] idx;
   logic [TAG_W-1:0]      tag;
   logic                  hit, accept, is_jalr, fill, load_out, issue_miss;
   logic [31:0]           src_word, src_next, imm_b, imm_j;
   logic                  src_taken;

   assign bus.Decoder_ins_ready      = ins_ready;
   assign bus.Decoder_ins            = ins_q;
   assign bus.Decoder_pc             = pc_q;
   assign bus.Decoder_predict_nxt_pc = pred_q;
   assign bus.MC_req                 = mc_req;
   assign bus.MC_addr                = mc_addr;

   // Cache probe plus prediction of whichever word is about to be presented:
   // the cached word on a hit, or the returning memory word at the end of a miss.
   always_comb begin
      idx        = fetch_pc[ICACHE_IDX+1:2];
      tag        = fetch_pc[31:ICACHE_IDX+2];
      hit        = valid[idx] && (tag_mem[idx] == tag);
      accept     = ins_ready && !bus.Decoder_stall;
      is_jalr    = (ins_q[6:0] == OP_JALR);
      src_word   = (state == MISS) ? bus.MC_data : data_mem[idx];
      imm_b      = {{20{src_word[31]}}, src_word[7], src_word[30:25], src_word[11:8], 1'b0};
      imm_j      = {{12{src_word[31]}}, src_word[19:12], src_word[20], src_word[30:21], 1'b0};
      src_taken  = 1'b0;
      src_next   = fetch_pc + 32'd4;
      case (src_word[6:0])
         OP_BRANCH: if (src_word[31]) begin
            src_taken = 1'b1;
            src_next  = fetch_pc + imm_b;
         end
         OP_JAL:    src_next = fetch_pc + imm_j;
         default:   ;
      endcase
      fill       = (state == MISS) && bus.MC_done && !bus.ROB_clear;
      issue_miss = (state == FETCH) && !hit && !bus.ROB_clear;
      load_out   = ((state == FETCH) && hit && !bus.ROB_clear) || fill;
   end

   // Next-state logic. A flush while a read is outstanding has to wait out
   // the memory controller in DRAIN, since requests cannot be aborted.
   always_comb begin
      next_state = state;
      case (state)
         FETCH:     next_state = hit ? PRESENT : MISS;
         MISS:      if (bus.MC_done) next_state = PRESENT;
         PRESENT:   if (accept) next_state = is_jalr ? WAIT_JALR : FETCH;
         WAIT_JALR: if (bus.Decoder_clear) next_state = FETCH;
         DRAIN:     if (bus.MC_done) next_state = FETCH;
         default:   next_state = FETCH;
      endcase
      if (bus.ROB_clear) begin
         if ((state == MISS || state == DRAIN) && !bus.MC_done) next_state = DRAIN;
         else next_state = FETCH;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state <= FETCH;
      else if (rdy_in) state <= next_state;
   end

   // PC, presentation registers and memory request; the ROB flush overrides
   // any same-cycle accept so the accepted instruction's successor is dropped.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         fetch_pc  <= RESET_PC;
         valid     <= '0;
         ins_ready <= 1'b0;
         ins_q     <= '0;
         pc_q      <= '0;
         pred_q    <= '0;
         mc_req    <= 1'b0;
         mc_addr   <= '0;
      end else if (rdy_in) begin
         if (fill) valid[idx] <= 1'b1;
         if (bus.ROB_clear) fetch_pc <= bus.ROB_new_pc;
         else if (state == PRESENT && accept && !is_jalr) fetch_pc <= pred_q;
         else if (state == WAIT_JALR && bus.Decoder_clear) fetch_pc <= bus.Decoder_new_addr & ~32'd1;
         if (bus.ROB_clear) ins_ready <= 1'b0;
         else if (load_out) ins_ready <= 1'b1;
         else if (accept) ins_ready <= 1'b0;
         if (load_out) begin
            ins_q  <= src_word;
            pc_q   <= {fetch_pc[31:1], src_taken};
            pred_q <= src_next;
         end
         if (issue_miss) begin
            mc_req  <= 1'b1;
            mc_addr <= fetch_pc;
         end else if ((state == MISS || state == DRAIN) && bus.MC_done) begin
            mc_req <= 1'b0;
         end
      end
   end

   // Cache data and tags need no reset; the valid bits guard them.
   always_ff @(posedge clk_in) begin
      if (rdy_in && fill) begin
         data_mem[idx] <= bus.MC_data;
         tag_mem[idx]  <= tag;
      end
   end
endmodule

// File: doc/ins_fetcher.md
Name: ins_fetcher

Overview:
- Instruction fetch unit; the producing end of the decoder's fetch interface.
- Holds the architectural fetch PC and keeps a small direct-mapped instruction cache, filled one word at a time from the memory controller.
- Presents one instruction per accepted handshake, with a static next-PC prediction.
- Honours decoder stall and JALR redirect, and ROB misprediction flush.

Parameters:
RESET_PC, 32'h0, fetch PC after reset
ICACHE_IDX, 4, log2 of cache entries (16 words); index = pc[ICACHE_IDX+1:2], tag = pc[31:ICACHE_IDX+2]

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  global enable; low freezes all state and outputs
Decoder_ins_ready  output  1  instruction on Decoder_ins/Decoder_pc is valid
Decoder_ins  output  32  instruction word
Decoder_pc  output  32  {pc[31:1], predicted_taken}; pc is word aligned, so bit 0 carries the prediction
Decoder_predict_nxt_pc  output  32  predicted next PC
Decoder_stall  input  1  decoder cannot accept the presented instruction this cycle
Decoder_clear  input  1  JALR redirect request
Decoder_new_addr  input  32  JALR target
ROB_clear  input  1  misprediction flush
ROB_new_pc  input  32  correct PC after flush
MC_req  output  1  word read request
MC_addr  output  32  word address
MC_done  input  1  one-cycle pulse; MC_data valid
MC_data  input  32  fetched word

Behaviour:
- Reset (rst_in=0, async):
  - fetch_pc=RESET_PC; all cache valid bits 0; state FETCH.
  - Decoder_ins_ready=0, Decoder_ins=0, Decoder_pc=0, Decoder_predict_nxt_pc=0, MC_req=0, MC_addr=0.
  - Reset mid-miss drops the request; the memory controller is reset alongside.
- rdy_in=0: no register changes.
- States:
  - FETCH: probe the cache at fetch_pc.
    - Hit: next cycle go to PRESENT with outputs loaded.
    - Miss: MC_req=1 and MC_addr=fetch_pc next cycle; go to MISS.
  - MISS: hold MC_req/MC_addr stable until MC_done.
    - On MC_done: write data/tag/valid into the cache, load the outputs from MC_data, MC_req=0, go to PRESENT.
  - PRESENT: Decoder_ins_ready=1; hold Decoder_ins, Decoder_pc and Decoder_predict_nxt_pc stable while Decoder_stall=1.
    - Accept = ins_ready & !Decoder_stall.
    - On accept, the next cycle deasserts Decoder_ins_ready.
    - Accepted JALR (opcode 1100111): go to WAIT_JALR.
    - Any other accepted instruction: fetch_pc = predict_nxt_pc, go to FETCH.
  - WAIT_JALR: no fetch, ins_ready=0; on Decoder_clear, fetch_pc = Decoder_new_addr & ~1, go to FETCH.
  - DRAIN: entered on a flush during MISS. Wait for MC_done, discard the data (no cache write), go to FETCH at the latched flush PC. MC_req stays asserted until MC_done; no abort exists.
- Prediction, combinational from the instruction word:
  - B-type (1100011): taken iff immB sign bit = 1 (backward). Taken: next = pc + sext(immB), bit0 = 1. Not taken: next = pc + 4, bit0 = 0.
  - JAL (1101111): next = pc + sext(immJ), bit0 = 0.
  - All others: pc + 4, bit0 = 0.
  - All additions are 32-bit with wrap.
- Flush priority: ROB_clear > Decoder_clear > normal advance.
  - ROB_clear in any state:
    - Next cycle: ins_ready=0, fetch_pc = ROB_new_pc.
    - From MISS: go to DRAIN. From any other state: go to FETCH.
    - Cache contents are kept.
  - Decoder_clear outside WAIT_JALR is ignored.
  - ROB_clear and accept in the same cycle: the flush wins and the accepted instruction's successor is not fetched.
- Hit latency: new fetch_pc → ins_ready in 1 cycle. Back-to-back hits give one instruction every 2 cycles (PRESENT → FETCH → PRESENT).
- Consecutive presentations must carry distinct Decoder_pc values, because the decoder detects new instructions by PC change. A self-loop (jal x0,0) must therefore re-present only after ins_ready has been low for at least 1 cycle; the decoder contract covers this case.

Test Plan:
- Reset with RESET_PC=0, cold cache; MC_done at cycle +3 with MC_data=32'h00500093 (addi) → MC_addr=0 held until done; then ins_ready=1, Decoder_pc=0, predict_nxt_pc=4; next fetch at 4.
- Present beq with immB=-8 at pc 0x20 → Decoder_pc=0x21, predict_nxt_pc=0x18. Same with immB=+16 → pc=0x20, predict=0x24.
- Decoder_stall high for 3 cycles while presenting → all Decoder_* outputs constant and no MC_req; after stall drops, the next pc is requested.
- JALR accepted at 0x40 → ins_ready=0 and no MC_req until Decoder_clear with new_addr=0x101 → fetch at 0x100.
- ROB_clear with new_pc=0x200 during MISS at 0x80 → MC_req held until MC_done, data discarded (a later fetch of 0x80 misses again), then fetch at 0x200.
- Loop re-fetching 0x0–0xC a second time → no MC_req, 1-cycle hit latency; rdy_in=0 for 5 cycles mid-loop → state frozen.
